// File: rtl/decode_stage.sv
// Registered instruction decode stage with valid/ready handshakes, a RAW/WAW scoreboard,
// an extension-word long-immediate mode and a saturating hazard-stall counter.
module decode_stage #(
    parameter int unsigned XLEN  = 16,
    parameter int unsigned NREGS = 8,
    parameter int unsigned IW    = 16,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned AW   = $clog2(NREGS),
    localparam int unsigned FW   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IW-1:0]    in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FW-1:0]    out_alu_ctrl,
    output logic [AW-1:0]    out_addr1,
    output logic [AW-1:0]    out_addr2,
    output logic [AW-1:0]    out_dest,
    output logic             out_reg_w_en,
    output logic             out_use_imm,
    output logic [XLEN-1:0]  out_imm,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_addr,
    output logic [CNT_W-1:0] stall_cnt
);

    // Instruction word layout, MSB first.
    typedef struct packed {
        logic [3:0]    opcode;
        logic [FW-1:0] funct;
        logic [2:0]    dest_reg;
        logic [2:0]    src_reg;
        logic          imm_valid;
        logic [2:0]    imm;
    } instr_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ALU1 = 4'b0001;
    localparam logic [3:0] OP_ALU2 = 4'b0010;
    localparam logic [3:0] OP_LONG = 4'b0011;

    typedef enum logic [0:0] {StRun, StExt} state_t;

    state_t           state_q, state_d;
    logic [NREGS-1:0] sb_q, sb_d, sb_eff, wb_mask;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [FW-1:0]    lat_funct_q, lat_funct_d;
    logic [AW-1:0]    lat_dest_q, lat_dest_d;
    logic [AW-1:0]    lat_src_q, lat_src_d;

    logic             out_valid_q, out_valid_d;
    logic [FW-1:0]    out_alu_ctrl_q, out_alu_ctrl_d;
    logic [AW-1:0]    out_addr1_q, out_addr1_d;
    logic [AW-1:0]    out_addr2_q, out_addr2_d;
    logic [AW-1:0]    out_dest_q, out_dest_d;
    logic             out_reg_w_en_q, out_reg_w_en_d;
    logic             out_use_imm_q, out_use_imm_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;

    instr_t           instr;
    logic [AW-1:0]    dec_dest, dec_src;
    logic             out_free, hazard, accept, load;

    assign instr    = instr_t'(in_word[15:0]);
    assign dec_dest = AW'(instr.dest_reg);
    assign dec_src  = AW'(instr.src_reg);

    always_comb begin
        wb_mask  = wb_valid ? (NREGS'(1) << wb_addr) : '0;
        sb_eff   = sb_q & ~wb_mask;
        out_free = !out_valid_q || out_ready;
        // The extension word is data, so it never hazards.
        hazard   = (state_q == StRun) && (instr.opcode != OP_NOP) &&
                   (sb_eff[dec_dest] || (!instr.imm_valid && sb_eff[dec_src]));
        in_ready = !rst && out_free && !hazard;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        state_d        = state_q;
        lat_funct_d    = lat_funct_q;
        lat_dest_d     = lat_dest_q;
        lat_src_d      = lat_src_q;
        load           = 1'b0;
        out_alu_ctrl_d = out_alu_ctrl_q;
        out_addr1_d    = out_addr1_q;
        out_addr2_d    = out_addr2_q;
        out_dest_d     = out_dest_q;
        out_reg_w_en_d = out_reg_w_en_q;
        out_use_imm_d  = out_use_imm_q;
        out_imm_d      = out_imm_q;

        if (accept) begin
            if (state_q == StExt) begin
                load           = 1'b1;
                state_d        = StRun;
                out_alu_ctrl_d = lat_funct_q;
                out_addr1_d    = lat_dest_q;
                out_addr2_d    = lat_src_q;
                out_dest_d     = lat_dest_q;
                out_reg_w_en_d = 1'b1;
                out_use_imm_d  = 1'b1;
                out_imm_d      = XLEN'(in_word);
            end else if (instr.opcode == OP_LONG) begin
                state_d     = StExt;
                lat_funct_d = instr.funct;
                lat_dest_d  = dec_dest;
                lat_src_d   = dec_src;
            end else if (instr.opcode != OP_NOP) begin
                load           = 1'b1;
                out_alu_ctrl_d = instr.funct;
                out_addr1_d    = dec_dest;
                out_addr2_d    = dec_src;
                out_dest_d     = dec_dest;
                out_reg_w_en_d = (instr.opcode == OP_ALU1) || (instr.opcode == OP_ALU2);
                out_use_imm_d  = instr.imm_valid;
                out_imm_d      = XLEN'(instr.imm);
            end
        end

        if (load) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        // Set after clear so an issuing writer wins over a same-cycle write-back.
        sb_d = sb_eff;
        if (load && out_reg_w_en_d) begin
            sb_d = sb_d | (NREGS'(1) << out_dest_d);
        end

        stall_cnt_d = stall_cnt_q;
        if ((state_q == StRun) && in_valid && out_free && hazard && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StRun;
            sb_q           <= '0;
            stall_cnt_q    <= '0;
            lat_funct_q    <= '0;
            lat_dest_q     <= '0;
            lat_src_q      <= '0;
            out_valid_q    <= 1'b0;
            out_alu_ctrl_q <= '0;
            out_addr1_q    <= '0;
            out_addr2_q    <= '0;
            out_dest_q     <= '0;
            out_reg_w_en_q <= 1'b0;
            out_use_imm_q  <= 1'b0;
            out_imm_q      <= '0;
        end else begin
            state_q        <= state_d;
            sb_q           <= sb_d;
            stall_cnt_q    <= stall_cnt_d;
            lat_funct_q    <= lat_funct_d;
            lat_dest_q     <= lat_dest_d;
            lat_src_q      <= lat_src_d;
            out_valid_q    <= out_valid_d;
            out_alu_ctrl_q <= out_alu_ctrl_d;
            out_addr1_q    <= out_addr1_d;
            out_addr2_q    <= out_addr2_d;
            out_dest_q     <= out_dest_d;
            out_reg_w_en_q <= out_reg_w_en_d;
            out_use_imm_q  <= out_use_imm_d;
            out_imm_q      <= out_imm_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_alu_ctrl = out_alu_ctrl_q;
    assign out_addr1    = out_addr1_q;
    assign out_addr2    = out_addr2_q;
    assign out_dest     = out_dest_q;
    assign out_reg_w_en = out_reg_w_en_q;
    assign out_use_imm  = out_use_imm_q;
    assign out_imm      = out_imm_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed stimulus, a per-cycle behavioural model and literal checks.
module tb_decode_stage;

    localparam int CNT_W = 3;

    typedef struct packed {
        logic        valid;
        logic [1:0]  alu;
        logic [2:0]  a1;
        logic [2:0]  a2;
        logic [2:0]  dest;
        logic        wen;
        logic        ui;
        logic [15:0] imm;
    } op_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [15:0]      in_word;
    logic             out_valid, out_ready;
    logic [1:0]       out_alu_ctrl;
    logic [2:0]       out_addr1, out_addr2, out_dest;
    logic             out_reg_w_en, out_use_imm;
    logic [15:0]      out_imm;
    logic             wb_valid;
    logic [2:0]       wb_addr;
    logic [CNT_W-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(16), .NREGS(8), .IW(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_ctrl(out_alu_ctrl),
        .out_addr1(out_addr1), .out_addr2(out_addr2), .out_dest(out_dest),
        .out_reg_w_en(out_reg_w_en), .out_use_imm(out_use_imm), .out_imm(out_imm),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .stall_cnt(stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input int op, input int f, input int d, input int s,
                                       input int iv, input int imm);
        return {op[3:0], f[1:0], d[2:0], s[2:0], iv[0], imm[2:0]};
    endfunction

    function automatic op_t mkop(input int alu, input int a1, input int a2, input int dest,
                                 input int wen, input int ui, input int imm);
        op_t o;
        o.valid = 1'b1; o.alu = alu[1:0]; o.a1 = a1[2:0]; o.a2 = a2[2:0];
        o.dest = dest[2:0]; o.wen = wen[0]; o.ui = ui[0]; o.imm = imm[15:0];
        return o;
    endfunction

    // Behavioural model state
    bit        pend [8];
    bit        pend_now [8];
    bit        m_ext;
    int        m_stall;
    op_t       m_out;
    op_t       dut_out;
    logic [1:0] lat_f;
    logic [2:0] lat_d, lat_s;
    op_t       delivered [$];

    always @(negedge clk) begin
        int  op, f, d, s, iv, im;
        bit  free, haz, exp_rdy;
        dut_out = '{out_valid, out_alu_ctrl, out_addr1, out_addr2, out_dest, out_reg_w_en,
                    out_use_imm, out_imm};
        if (rst) begin
            foreach (pend[i]) pend[i] = 1'b0;
            m_ext   = 1'b0;
            m_stall = 0;
            m_out   = '0;
            check("in_ready_in_reset", in_ready, 0);
            check("outputs_in_reset", dut_out, m_out);
            check("stall_in_reset", stall_cnt, 0);
        end else begin
            op = in_word[15:12]; f = in_word[11:10]; d = in_word[9:7]; s = in_word[6:4];
            iv = in_word[3]; im = in_word[2:0];
            foreach (pend[i]) pend_now[i] = pend[i];
            if (wb_valid) pend_now[wb_addr] = 1'b0;
            free    = !m_out.valid || out_ready;
            haz     = !m_ext && op != 0 && (pend_now[d] || (iv == 0 && pend_now[s]));
            exp_rdy = free && !haz;

            check("in_ready", in_ready, exp_rdy);
            check("outputs", dut_out, m_out);
            check("stall_cnt", stall_cnt, m_stall);
            if (out_valid && out_ready) delivered.push_back(dut_out);

            if (!m_ext && in_valid && free && haz && m_stall < (1 << CNT_W) - 1) m_stall++;
            if (m_out.valid && out_ready) m_out.valid = 1'b0;
            if (in_valid && exp_rdy) begin
                if (m_ext) begin
                    m_out = mkop(lat_f, lat_d, lat_s, lat_d, 1, 1, in_word);
                    m_ext = 1'b0;
                end else if (op == 3) begin
                    m_ext = 1'b1; lat_f = f[1:0]; lat_d = d[2:0]; lat_s = s[2:0];
                end else if (op != 0) begin
                    m_out = mkop(f, d, s, d, (op == 1 || op == 2) ? 1 : 0, iv, im);
                end
                if (m_out.valid && m_out.wen && !m_ext && (op != 0 || in_word != 0 || 1))
                    ;
            end
            foreach (pend[i]) pend[i] = pend_now[i];
            if (in_valid && exp_rdy && m_out.valid && m_out.wen &&
                (m_out.dest == d[2:0] || m_out.imm == in_word) && (op == 1 || op == 2 ||
                (m_out.ui && m_out.imm == in_word)))
                pend[m_out.dest] = 1'b1;
        end
    end

    task automatic set_in(input bit v, input logic [15:0] w, input bit r, input bit wbv,
                          input int wba);
        in_valid = v; in_word = w; out_ready = r; wb_valid = wbv; wb_addr = wba[2:0];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 16'h0, 1, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2 check("reset_out_valid", out_valid, 0);
        check("reset_stall", stall_cnt, 0);
        tick;

        // Writer r1, read r2
        set_in(1, mk(1, 1, 1, 2, 0, 0), 1, 0, 0);
        #2 check("A_ready", in_ready, 1);
        tick;
        check("A_valid", out_valid, 1);
        check("A_addr1", out_addr1, 1);
        check("A_addr2", out_addr2, 2);
        check("A_wen", out_reg_w_en, 1);

        // RAW on r1 stalls until write-back
        set_in(1, mk(2, 2, 4, 1, 0, 0), 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #2 check("B_stalled", in_ready, 0);
            tick;
        end
        check("stall_3", stall_cnt, 3);
        set_in(1, mk(2, 2, 4, 1, 0, 0), 1, 1, 1);
        #2 check("B_wb_ready", in_ready, 1);
        tick;
        check("B_addr1", out_addr1, 4);
        check("stall_hold", stall_cnt, 3);

        // Long immediate
        set_in(1, mk(3, 3, 3, 0, 0, 0), 1, 0, 0);
        tick;
        #2 check("ext_no_out", out_valid, 0);
        set_in(1, 16'hBEEF, 1, 0, 0);
        #0 check("ext_ready", in_ready, 1);
        tick;
        check("C_valid", out_valid, 1);
        check("C_use_imm", out_use_imm, 1);
        check("C_imm", out_imm, 16'hBEEF);
        check("C_dest", out_dest, 3);
        check("C_alu", out_alu_ctrl, 3);
        set_in(0, 16'h0, 1, 0, 0);
        tick;
        check("ext_word_no_op", out_valid, 0);

        // Back-pressure
        set_in(1, mk(4, 1, 5, 0, 1, 2), 1, 0, 0);
        tick;
        set_in(1, mk(1, 2, 6, 0, 1, 5), 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #2 check("bp_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_addr1", out_addr1, 5);
            check("bp_imm", out_imm, 2);
            check("bp_wen", out_reg_w_en, 0);
            tick;
        end
        set_in(1, mk(1, 2, 6, 0, 1, 5), 1, 0, 0);
        #2 check("bp_release_ready", in_ready, 1);
        tick;
        check("bp_op2_addr1", out_addr1, 6);
        set_in(0, 16'h0, 1, 0, 0);
        tick;
        check("bp_drained", out_valid, 0);

        // Same-cycle release and re-set of r3, then saturate the stall counter on r3
        set_in(1, mk(1, 0, 3, 7, 1, 1), 1, 1, 3);
        #2 check("W3_ready", in_ready, 1);
        tick;
        set_in(1, mk(5, 0, 3, 0, 1, 0), 1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            #2 check("r3_pending", in_ready, 0);
            tick;
        end
        check("stall_saturated", stall_cnt, 7);
        set_in(1, mk(5, 0, 3, 0, 1, 0), 1, 1, 3);
        #2 check("H3_ready", in_ready, 1);
        tick;
        set_in(0, 16'h0, 1, 0, 0);
        tick;
        tick;

        check("log_size", delivered.size(), 7);
        if (delivered.size() == 7) begin
            check("log_A", delivered[0], mkop(1, 1, 2, 1, 1, 0, 0));
            check("log_B", delivered[1], mkop(2, 4, 1, 4, 1, 0, 0));
            check("log_C", delivered[2], mkop(3, 3, 0, 3, 1, 1, 16'hBEEF));
            check("log_op1", delivered[3], mkop(1, 5, 0, 5, 0, 1, 2));
            check("log_op2", delivered[4], mkop(2, 6, 0, 6, 1, 1, 5));
            check("log_W3", delivered[5], mkop(0, 3, 7, 3, 1, 1, 1));
            check("log_H3", delivered[6], mkop(0, 3, 0, 3, 0, 1, 0));
        end

        // Reset while in EXT
        set_in(1, mk(3, 0, 2, 0, 1, 0), 1, 0, 0);
        tick;
        set_in(0, 16'h0, 1, 0, 0);
        rst = 1'b1;
        #2 check("rst_out_valid", out_valid, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_in_ready", in_ready, 0);
        tick;
        rst = 1'b0;
        set_in(1, mk(1, 1, 4, 2, 1, 3), 1, 0, 0);
        #2 check("post_rst_ready", in_ready, 1);
        tick;
        check("post_rst_valid", out_valid, 1);
        check("post_rst_addr1", out_addr1, 4);
        check("post_rst_imm", out_imm, 3);
        check("post_rst_dest", out_dest, 4);
        set_in(0, 16'h0, 1, 0, 0);
        tick;
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
